// File: rtl/ca_pkg.sv
// ca_pkg
// Definitions shared by the cellular-automaton row engine and its
// next-generation evaluator:
//   RULE_W   width of a Wolfram rule number (8 bits, rules 0-255)
//   state_t  frame-generation FSM states (IDLE, EMIT, NEXT, DONE)
//   nbrIdx   packs a 3-cell neighbourhood into a rule-bit index
// Build option CA_WRAP_EN (used by ca_next_row) selects a toroidal boundary.
`timescale 1ns/1ps

package ca_pkg;

  localparam int RULE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The left neighbour is the most significant bit of the index, which is the
  // ordering that makes the index select bit n of the Wolfram rule number.
  function automatic logic [2:0] nbrIdx(input logic left, input logic centre,
                                        input logic right);
    return {left, centre, right};
  endfunction

endpackage

// File: rtl/ca_next_row.sv
// ca_next_row
// Purely combinational next-generation evaluator for a 1-D elementary
// cellular automaton. Every cell of the row is updated in parallel from its
// three-cell neighbourhood using the supplied rule number.
// Ports:
//   i_row   [WIDTH-1:0]   current generation, bit i = cell x=i
//   i_rule  [RULE_W-1:0]  Wolfram rule number
//   o_next  [WIDTH-1:0]   next generation
// Build option CA_WRAP_EN:
//   defined   - toroidal boundary, cell 0 and cell WIDTH-1 are neighbours
//   undefined - null boundary, cells beyond the row read as dead
`timescale 1ns/1ps

module ca_next_row
  import ca_pkg::*;
#(
  parameter int WIDTH = 640
) (
  input  logic [WIDTH-1:0]  i_row,
  input  logic [RULE_W-1:0] i_rule,
  output logic [WIDTH-1:0]  o_next
);

  logic             w_edgeL;
  logic             w_edgeR;
  logic [WIDTH+1:0] w_ext;

  // Values seen beyond the left end of cell 0 and the right end of cell WIDTH-1.
`ifdef CA_WRAP_EN
  assign w_edgeL = i_row[WIDTH-1];
  assign w_edgeR = i_row[0];
`else
  assign w_edgeL = 1'b0;
  assign w_edgeR = 1'b0;
`endif

  // Row padded with one boundary cell on each side so every real cell has a
  // uniform neighbourhood: cell i sees w_ext[i], w_ext[i+1], w_ext[i+2].
  assign w_ext = {w_edgeR, i_row, w_edgeL};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign o_next[i] = i_rule[nbrIdx(w_ext[i], w_ext[i+1], w_ext[i+2])];
  end

endmodule

// File: rtl/ca_row_engine.sv
// ca_row_engine
// Elementary cellular-automaton frame generator. On a start request it latches
// a rule and a seed row, then streams HEIGHT generations of a WIDTH-cell row as
// a raster of 1-bit pixels over a valid/ready handshake, one pixel per transfer,
// with one idle cycle between rows while the next generation is computed.
// Ports:
//   iCLK      clock
//   iRST_N    asynchronous active-low reset
//   iStart    start-frame request, honoured only when idle
//   iClear    synchronous abort back to idle, no completion pulse
//   iRule     rule number, latched at start
//   iSeedSel  0: single live cell at WIDTH/2, 1: use iSeed
//   iSeed     seed row, bit i = cell x=i, latched at start
//   oValid    pixel available
//   iReady    sink accepts the pixel when oValid & iReady
//   oPix      cell state of the pixel (1 = live)
//   oX, oY    pixel column / generation number
//   oBusy     high from start accept until the return to idle
//   oDone     one-cycle pulse after the last pixel of a frame transferred
// Build option CA_WRAP_EN (in ca_next_row) selects a toroidal row boundary.
`timescale 1ns/1ps

module ca_row_engine
  import ca_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 10
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic              iClear,
  input  logic [RULE_W-1:0] iRule,
  input  logic              iSeedSel,
  input  logic [WIDTH-1:0]  iSeed,
  output logic              oValid,
  input  logic              iReady,
  output logic              oPix,
  output logic [XW-1:0]     oX,
  output logic [YW-1:0]     oY,
  output logic              oBusy,
  output logic              oDone
);

  localparam logic [XW-1:0]    X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [WIDTH-1:0] CENTRE_SEED = WIDTH'(1) << (WIDTH / 2);

  state_t              r_state;
  logic [WIDTH-1:0]    r_row;
  logic [RULE_W-1:0]   r_rule;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic                r_valid;
  logic                r_pix;
  logic                r_busy;
  logic                r_done;

  logic [WIDTH-1:0]    w_nextRow;
  logic [WIDTH-1:0]    w_seedRow;
  logic [WIDTH-1:0]    w_rowShift;
  logic [XW-1:0]       w_xInc;
  logic                w_xLast;
  logic                w_yLast;

  ca_next_row #(
    .WIDTH (WIDTH)
  ) u_nextRow (
    .i_row  (r_row),
    .i_rule (r_rule),
    .o_next (w_nextRow)
  );

  assign w_seedRow  = iSeedSel ? iSeed : CENTRE_SEED;
  assign w_xInc     = r_x + XW'(1);
  assign w_xLast    = (r_x == X_LAST);
  assign w_yLast    = (r_y == Y_LAST);
  // The pixel register is loaded one column ahead, so the cell that becomes
  // visible after a transfer is picked out by shifting rather than indexing.
  assign w_rowShift = r_row >> w_xInc;

  // Frame FSM. All outputs are registers updated together with the state, so
  // oPix/oX/oY always describe the pixel currently offered and simply hold
  // while the sink stalls. iClear is checked before the state decode so an
  // abort takes priority over a start request arriving in the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_rule  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_pix   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (iClear) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_x     <= '0;
        r_y     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (iStart) begin
              r_rule  <= iRule;
              r_row   <= w_seedRow;
              r_x     <= '0;
              r_y     <= '0;
              r_pix   <= w_seedRow[0];
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_EMIT;
            end
          end
          ST_EMIT: begin
            if (r_valid && iReady) begin
              if (!w_xLast) begin
                r_x   <= w_xInc;
                r_pix <= w_rowShift[0];
              end else if (!w_yLast) begin
                r_valid <= 1'b0;
                r_state <= ST_NEXT;
              end else begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
          ST_NEXT: begin
            r_row   <= w_nextRow;
            r_x     <= '0;
            r_y     <= r_y + YW'(1);
            r_pix   <= w_nextRow[0];
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign oValid = r_valid;
  assign oPix   = r_pix;
  assign oX     = r_x;
  assign oY     = r_y;
  assign oBusy  = r_busy;
  assign oDone  = r_done;

endmodule
